// File: rtl/control_sequencer_if.sv
// Strobe bundle between the hardwired control sequencer
// and the 32-bit bus datapath it steers.
interface control_sequencer_if #(
  parameter int OPC_W = 5
);
  logic             Stop;
  logic [OPC_W-1:0] IR_opcode;

  logic PCout, PCin, IncPC, MARin;
  logic MDRin, MDRout, IRin, Read;

  logic Yin, Zin, Zlowout, HIout, LOout;
  logic Gra, Grb, Grc, Rin, Rout;

  logic Write, Zhighout, HIin, LOin, BAout;
  logic Cout, Inportin, Inportout;
  logic Outportin, CONin;

  logic [OPC_W-1:0] opcode;
  logic             Run;
  logic             Instr_done;

  modport master (
    input  Stop, IR_opcode,
    output PCout, PCin, IncPC, MARin,
    output MDRin, MDRout, IRin, Read,
    output Yin, Zin, Zlowout, HIout, LOout,
    output Gra, Grb, Grc, Rin, Rout,
    output Write, Zhighout, HIin, LOin, BAout,
    output Cout, Inportin, Inportout,
    output Outportin, CONin,
    output opcode, Run, Instr_done
  );

  modport slave (
    output Stop, IR_opcode,
    input  PCout, PCin, IncPC, MARin,
    input  MDRin, MDRout, IRin, Read,
    input  Yin, Zin, Zlowout, HIout, LOout,
    input  Gra, Grb, Grc, Rin, Rout,
    input  Write, Zhighout, HIin, LOin, BAout,
    input  Cout, Inportin, Inportout,
    input  Outportin, CONin,
    input  opcode, Run, Instr_done
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, execute T3-T5,
// strobes decoded from the T-state and IR opcode.
module control_sequencer #(
  parameter int               OPC_W    = 5,
  parameter logic [OPC_W-1:0] ALU_MAX  = 5'h08,
  parameter logic [OPC_W-1:0] MFHI_OPC = 5'h17,
  parameter logic [OPC_W-1:0] MFLO_OPC = 5'h18,
  parameter logic [OPC_W-1:0] NOP_OPC  = 5'h19,
  parameter logic [OPC_W-1:0] HALT_OPC = 5'h1A
) (
  input logic                 Clock,
  input logic                 clear,
  control_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    RST,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    HALTED
  } state_t;

  state_t state;

  logic is_alu;
  logic is_mfhi;
  logic is_mflo;
  logic is_nop;
  logic is_halt;

  logic pc_out, pc_in, inc_pc, mar_in;
  logic mdr_in, mdr_out, ir_in, rd;
  logic y_in, z_in, zlow_out;
  logic hi_out, lo_out;
  logic gra, grb, grc, r_in, r_out;
  logic [OPC_W-1:0] alu_opc;
  logic run;
  logic done;

  assign is_alu  = bus.IR_opcode <= ALU_MAX;
  assign is_mfhi = bus.IR_opcode == MFHI_OPC;
  assign is_mflo = bus.IR_opcode == MFLO_OPC;
  assign is_nop  = bus.IR_opcode == NOP_OPC;
  assign is_halt = bus.IR_opcode == HALT_OPC;

  // Stop only matters on the instruction-end cycle.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state <= RST;
    end else begin
      unique case (state)
        RST: state <= T0;
        T0:  state <= T1;
        T1:  state <= T2;
        T2:  state <= T3;
        T3: begin
          if (is_alu)
            state <= T4;
          else if (is_halt || bus.Stop)
            state <= HALTED;
          else
            state <= T0;
        end
        T4:  state <= T5;
        T5:  state <= bus.Stop ? HALTED : T0;
        HALTED: state <= HALTED;
        default: state <= RST;
      endcase
    end
  end

  always_comb begin
    pc_out   = 1'b0;
    pc_in    = 1'b0;
    inc_pc   = 1'b0;
    mar_in   = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ir_in    = 1'b0;
    rd       = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    hi_out   = 1'b0;
    lo_out   = 1'b0;
    gra      = 1'b0;
    grb      = 1'b0;
    grc      = 1'b0;
    r_in     = 1'b0;
    r_out    = 1'b0;
    alu_opc  = '0;
    done     = 1'b0;
    unique case (state)
      T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        rd       = 1'b1;
        mdr_in   = 1'b1;
      end
      T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      T3: begin
        unique case (1'b1)
          is_alu: begin
            grb   = 1'b1;
            r_out = 1'b1;
            y_in  = 1'b1;
          end
          is_mfhi: begin
            gra    = 1'b1;
            r_in   = 1'b1;
            hi_out = 1'b1;
            done   = 1'b1;
          end
          is_mflo: begin
            gra    = 1'b1;
            r_in   = 1'b1;
            lo_out = 1'b1;
            done   = 1'b1;
          end
          // nop, halt and unlisted opcodes just retire
          default: done = 1'b1;
        endcase
      end
      T4: begin
        grc     = 1'b1;
        r_out   = 1'b1;
        z_in    = 1'b1;
        alu_opc = bus.IR_opcode;
      end
      T5: begin
        zlow_out = 1'b1;
        gra      = 1'b1;
        r_in     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign run = (state != RST) && (state != HALTED);

  assign bus.PCout   = pc_out;
  assign bus.PCin    = pc_in;
  assign bus.IncPC   = inc_pc;
  assign bus.MARin   = mar_in;
  assign bus.MDRin   = mdr_in;
  assign bus.MDRout  = mdr_out;
  assign bus.IRin    = ir_in;
  assign bus.Read    = rd;

  assign bus.Yin     = y_in;
  assign bus.Zin     = z_in;
  assign bus.Zlowout = zlow_out;
  assign bus.HIout   = hi_out;
  assign bus.LOout   = lo_out;
  assign bus.Gra     = gra;
  assign bus.Grb     = grb;
  assign bus.Grc     = grc;
  assign bus.Rin     = r_in;
  assign bus.Rout    = r_out;

  assign bus.Write     = 1'b0;
  assign bus.Zhighout  = 1'b0;
  assign bus.HIin      = 1'b0;
  assign bus.LOin      = 1'b0;
  assign bus.BAout     = 1'b0;
  assign bus.Cout      = 1'b0;
  assign bus.Inportin  = 1'b0;
  assign bus.Inportout = 1'b0;
  assign bus.Outportin = 1'b0;
  assign bus.CONin     = 1'b0;

  assign bus.opcode     = alu_opc;
  assign bus.Run        = run;
  assign bus.Instr_done = done;

  logic unused_nop;
  assign unused_nop = is_nop;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench: an instruction-level model
// predicts every cycle's strobe vector for the sequencer.
module tb_control_sequencer;

  typedef struct packed {
    logic       Run;
    logic       Instr_done;
    logic [4:0] opcode;
    logic PCout, PCin, IncPC, MARin;
    logic MDRin, MDRout, IRin, Read;
    logic Yin, Zin, Zlowout, HIout, LOout;
    logic Gra, Grb, Grc, Rin, Rout;
    logic [9:0] tied;
  } vec_t;

  logic Clock;
  logic clear;

  control_sequencer_if #(.OPC_W(5)) bus ();

  control_sequencer dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus.master)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  vec_t act;
  assign act = {
    bus.Run, bus.Instr_done, bus.opcode,
    bus.PCout, bus.PCin, bus.IncPC, bus.MARin,
    bus.MDRin, bus.MDRout, bus.IRin, bus.Read,
    bus.Yin, bus.Zin, bus.Zlowout,
    bus.HIout, bus.LOout,
    bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
    bus.Write, bus.Zhighout, bus.HIin, bus.LOin,
    bus.BAout, bus.Cout, bus.Inportin,
    bus.Inportout, bus.Outportin, bus.CONin
  };

  vec_t exp_q[$];
  int   tag_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cur_instr = 0;

  always @(negedge Clock) begin
    vec_t e;
    int   t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL strobes instr%0d t=%0t act=%h exp=%h",
                 t, $time, act, e);
      end
    end
  end

  task automatic push(input vec_t v);
    exp_q.push_back(v);
    tag_q.push_back(cur_instr);
  endtask

  // Reference: per-instruction micro-step list from the ISA table.
  task automatic build(input logic [4:0] opc, output vec_t seq[$]);
    vec_t v;
    seq = {};
    v = '0; v.Run = 1;
    v.PCout = 1; v.MARin = 1; v.IncPC = 1; v.Zin = 1;
    seq.push_back(v);
    v = '0; v.Run = 1;
    v.Zlowout = 1; v.PCin = 1; v.Read = 1; v.MDRin = 1;
    seq.push_back(v);
    v = '0; v.Run = 1;
    v.MDRout = 1; v.IRin = 1;
    seq.push_back(v);
    if (opc <= 5'h08) begin
      v = '0; v.Run = 1;
      v.Grb = 1; v.Rout = 1; v.Yin = 1;
      seq.push_back(v);
      v = '0; v.Run = 1;
      v.Grc = 1; v.Rout = 1; v.Zin = 1; v.opcode = opc;
      seq.push_back(v);
      v = '0; v.Run = 1;
      v.Zlowout = 1; v.Gra = 1; v.Rin = 1; v.Instr_done = 1;
      seq.push_back(v);
    end else begin
      v = '0; v.Run = 1; v.Instr_done = 1;
      if (opc == 5'h17) begin
        v.Gra = 1; v.Rin = 1; v.HIout = 1;
      end else if (opc == 5'h18) begin
        v.Gra = 1; v.Rin = 1; v.LOout = 1;
      end
      seq.push_back(v);
    end
  endtask

  // stop_mode: 0 random, 1 high through execute, 2 low
  task automatic run_instr(input logic [4:0] opc,
                           input int stop_mode,
                           input int abort_at,
                           input int hold);
    vec_t seq[$];
    bit   halt_next;
    build(opc, seq);
    cur_instr++;
    for (int i = 0; i < seq.size(); i++) begin
      @(posedge Clock); #1;
      bus.IR_opcode = (i < 3) ? 5'($urandom) : opc;
      case (stop_mode)
        0:       bus.Stop = ($urandom_range(0, 5) == 0);
        1:       bus.Stop = (i >= 3);
        default: bus.Stop = 1'b0;
      endcase
      if (i == abort_at) begin
        clear = 1'b0;
        push('0);
        @(posedge Clock); #1;
        clear = 1'b1;
        push('0);
        return;
      end
      push(seq[i]);
    end
    halt_next = (opc == 5'h1A) || bus.Stop;
    if (halt_next) begin
      repeat (hold) begin
        @(posedge Clock); #1;
        bus.Stop = 1'($urandom);
        bus.IR_opcode = 5'($urandom);
        push('0);
      end
      @(posedge Clock); #1;
      clear = 1'b0;
      push('0);
      @(posedge Clock); #1;
      clear = 1'b1;
      push('0);
    end
  endtask

  initial begin
    logic [4:0] opc;
    int         ab;
    clear = 1'b1;
    bus.Stop = 1'b0;
    bus.IR_opcode = '0;
    #1 clear = 1'b0;
    @(posedge Clock); #1;
    push('0);
    @(posedge Clock); #1;
    clear = 1'b1;
    push('0);

    run_instr(5'h03, 2, 4, 0);
    run_instr(5'h18, 2, -1, 0);
    run_instr(5'h00, 2, -1, 0);
    run_instr(5'h17, 2, -1, 0);
    run_instr(5'h19, 2, -1, 0);
    run_instr(5'h08, 1, -1, 3);
    run_instr(5'h1A, 2, -1, 10);
    run_instr(5'h09, 2, -1, 0);
    run_instr(5'h1F, 1, -1, 2);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    opc = 5'($urandom_range(0, 8));
        2:       opc = 5'($urandom_range(5'h17, 5'h19));
        3:       opc = ($urandom_range(0, 3) == 0) ? 5'h1A : 5'h19;
        default: opc = 5'($urandom);
      endcase
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
      run_instr(opc, 0, ab, $urandom_range(1, 6));
    end

    @(posedge Clock);
    @(negedge Clock);
    @(negedge Clock);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
